vga_timing_gen: RTL and testbench

//   Upstream timing stage of the VGA display path. Divides CLK100MHZ into a pixel strobe.

---
 rtl/vga_timing_gen.sv | 86 ++++++++
 tb/tb_vga_timing_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Pixel-strobe divider, raster counters, registered sync/blank decodes and per-frame value snapshot.
// Decodes share the counters' edge (zero skew); free-running, no backpressure.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int DATA_W   = 16
) (
    input  logic              CLK100MHZ,
    input  logic              rst,
    input  logic [DATA_W-1:0] reg_value,
    output logic              pix_en,
    output logic [9:0]        h_cnt,
    output logic [9:0]        v_cnt,
    output logic              video_on,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic [DATA_W-1:0] reg_snap
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div, div_nxt;
    logic [9:0]       h_nxt, v_nxt;
    logic             h_wrap, frame_wrap;

    always_comb begin
        div_nxt    = (div == DIV_LAST) ? '0 : div + 1'b1;
        h_wrap     = pix_en && (h_cnt == H_LAST);
        frame_wrap = h_wrap && (v_cnt == V_LAST);
        h_nxt      = h_cnt;
        v_nxt      = v_cnt;
        if (pix_en) begin
            h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap)
                v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Decodes are computed from next-state counters so they land on the same edge.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            div         <= '0;
            pix_en      <= 1'b0;
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            reg_snap    <= '0;
        end else begin
            div         <= div_nxt;
            pix_en      <= (div_nxt == DIV_LAST);
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            video_on    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            hsync       <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? SYNC_POL : ~SYNC_POL;
            frame_start <= frame_wrap;
            if (frame_wrap)
                reg_snap <= reg_value;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen on a shrunken raster; expectations come from cycle arithmetic.
module tb_vga_timing_gen;

    localparam int CD  = 4;
    localparam int HA  = 8,  HFP = 2, HS = 3, HBP = 2;
    localparam int VA  = 5,  VFP = 1, VS = 2, VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int F   = HT * VT;
    localparam bit POL = 1'b0;

    typedef struct packed {
        logic        pe;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        vid;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] snap;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] reg_value = 16'h0001;
    logic        pix_en, video_on, hsync, vsync, frame_start;
    logic [9:0]  h_cnt, v_cnt;
    logic [15:0] reg_snap;

    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    logic [15:0] snap_m = 16'h0;
    obs_t exp_q[$];

    vga_timing_gen #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(POL), .DATA_W(16)
    ) dut (
        .CLK100MHZ(clk), .rst(rst_n), .reg_value(reg_value),
        .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt), .video_on(video_on),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .reg_snap(reg_snap)
    );

    always #5 clk = ~clk;

    // Raster position after k edges: the counters start one pixel before (0,0)
    // and step once every CD edges, so the linear position is (F-1 + k/CD) mod F.
    function automatic int raster_idx(input int kk);
        return (F - 1 + kk / CD) % F;
    endfunction

    function automatic obs_t model(input int kk, input logic [15:0] snap);
        obs_t o;
        int idx, h, v;
        idx    = raster_idx(kk);
        h      = idx % HT;
        v      = idx / HT;
        o.pe   = (kk % CD) == CD - 1;
        o.h    = 10'(h);
        o.v    = 10'(v);
        o.vid  = (h < HA) && (v < VA);
        o.hs   = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
        o.vs   = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
        o.fs   = (kk > 0) && (kk % CD == 0) && (idx == 0);
        o.snap = snap;
        return o;
    endfunction

    function automatic obs_t observe();
        return {pix_en, h_cnt, v_cnt, video_on, hsync, vsync, frame_start, reg_snap};
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pe=%b h=%0d v=%0d vid=%b hs=%b vs=%b fs=%b snap=%h, expected pe=%b h=%0d v=%0d vid=%b hs=%b vs=%b fs=%b snap=%h",
                     name, act.pe, act.h, act.v, act.vid, act.hs, act.vs, act.fs, act.snap,
                     exp.pe, exp.h, exp.v, exp.vid, exp.hs, exp.vs, exp.fs, exp.snap);
        end
    endtask

    // Monitor: every cycle's outputs are compared against the queued prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0)
            check_obs("cycle", observe(), exp_q.pop_front());
    end

    task automatic run_cycles(input int n, input bit randomize_value);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            if ((k % CD == 0) && raster_idx(k) == 0)
                snap_m = reg_value;
            exp_q.push_back(model(k, snap_m));
            @(negedge clk);
            if (randomize_value)
                reg_value = 16'($urandom);
        end
    endtask

    task automatic start_from_reset();
        k         = 0;
        snap_m    = 16'h0;
        reg_value = 16'h0001;
        rst_n     = 1'b1;
        run_cycles(CD + 2, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_obs("reset_state", observe(), model(0, 16'h0));
        @(negedge clk);
        start_from_reset();
        check_obs("first_snap", observe(), model(CD + 2, 16'h0001));
        run_cycles(2 * F * CD + 3, 1'b1);

        // Abandon a frame mid-raster; outputs must clear without any clock edge.
        run_cycles((F / 2) * CD, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_obs("async_reset", observe(), model(0, 16'h0));
        repeat (3) @(negedge clk);
        check_obs("held_reset", observe(), model(0, 16'h0));
        start_from_reset();
        check_obs("restart_snap", observe(), model(CD + 2, 16'h0001));
        run_cycles(2 * F * CD, 1'b1);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
